nor_sweep_ctrl: RTL and testbench

// Self-checking sequencer for the three NOR implementations (gate, behavioural, dataflow).
// On start it drives every 2-bit input vector into all three units in lock-step and waits a

---
 rtl/nor_sweep_if.sv | 31 +++
 rtl/nor_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_nor_sweep_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/nor_sweep_if.sv
// Bundle between the NOR sweep controller and its host / units under check.
// The slave side is the controller; the master side drives start/abort and the unit outputs.
interface nor_sweep_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             y_gate;
    logic             y_beh;
    logic             y_df;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_gate;
    logic [CNT_W-1:0] err_beh;
    logic [CNT_W-1:0] err_df;
    logic [1:0]       first_fail;
    logic             fail_seen;

    modport master (
        output start, abort, y_gate, y_beh, y_df,
        input  a, b, busy, done, pass, err_gate, err_beh, err_df, first_fail, fail_seen
    );

    modport slave (
        input  start, abort, y_gate, y_beh, y_df,
        output a, b, busy, done, pass, err_gate, err_beh, err_df, first_fail, fail_seen
    );
endinterface

// File: rtl/nor_sweep_ctrl.sv
// Sweeps all 2-bit vectors into three NOR implementations, waits a settle window,
// and accumulates saturating per-unit mismatch counts against a golden NOR.
module nor_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_PASSES      = 1,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    nor_sweep_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(N_PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]      state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [SC_W-1:0] settle_q, settle_d;
    logic [PC_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [1:0]      first_fail_q, first_fail_d;
    logic            fail_seen_q, fail_seen_d;
    logic            pass_q, pass_d;

    logic       abort_act;
    logic       clr;
    logic       chk;
    logic       golden;
    logic [2:0] y;
    logic [2:0] mismatch;
    logic [2:0] err_nz;

    assign abort_act = bus.abort && (state_q != ST_IDLE);
    assign clr       = (state_q == ST_IDLE) && bus.start;
    assign chk       = (state_q == ST_CHECK) && !abort_act;
    assign golden    = ~(vec_q[1] | vec_q[0]);
    assign y         = {bus.y_df, bus.y_beh, bus.y_gate};
    assign mismatch  = y ^ {3{golden}};

    // One saturating counter per unit: index 0 = gate, 1 = behavioural, 2 = dataflow.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_err
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (chk && mismatch[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign err_nz = {|g_err[2].cnt_q, |g_err[1].cnt_q, |g_err[0].cnt_q};

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        pass_cnt_d   = pass_cnt_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_SETTLE;
                    vec_d        = 2'd0;
                    settle_d     = '0;
                    pass_cnt_d   = '0;
                    first_fail_d = 2'd0;
                    fail_seen_d  = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SC_LAST) begin
                    settle_d = '0;
                    state_d  = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if ((|mismatch) && !fail_seen_q) begin
                    first_fail_d = vec_q;
                    fail_seen_d  = 1'b1;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = ST_SETTLE;
                end else if (pass_cnt_q != PC_LAST) begin
                    vec_d      = 2'd0;
                    pass_cnt_d = pass_cnt_q + 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    // Final verdict folds in this last sample before the counters update.
                    state_d = ST_DONE;
                    pass_d  = ~|(err_nz | mismatch);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_act) begin
            state_d      = ST_IDLE;
            vec_d        = vec_q;
            settle_d     = '0;
            pass_cnt_d   = pass_cnt_q;
            first_fail_d = first_fail_q;
            fail_seen_d  = fail_seen_q;
            pass_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            settle_q     <= '0;
            pass_cnt_q   <= '0;
            first_fail_q <= 2'd0;
            fail_seen_q  <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            pass_cnt_q   <= pass_cnt_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.a          = vec_q[1];
    assign bus.b          = vec_q[0];
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.pass       = pass_q;
    assign bus.err_gate   = g_err[0].cnt_q;
    assign bus.err_beh    = g_err[1].cnt_q;
    assign bus.err_df     = g_err[2].cnt_q;
    assign bus.first_fail = first_fail_q;
    assign bus.fail_seen  = fail_seen_q;
endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// Directed bench for nor_sweep_ctrl: three instances (defaults, N_PASSES=3, CNT_W=2/N_PASSES=2)
// fed by behavioural NOR models with per-unit fault injection.
module tb_nor_sweep_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic beh0_tie;
    logic df3_inv;
    logic gate5_inv;

    nor_sweep_if #(.CNT_W(8)) if0 ();
    nor_sweep_if #(.CNT_W(8)) if3 ();
    nor_sweep_if #(.CNT_W(2)) if5 ();

    nor_sweep_ctrl #(.SETTLE_CYCLES(2), .N_PASSES(1), .CNT_W(8)) u_def (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    nor_sweep_ctrl #(.SETTLE_CYCLES(2), .N_PASSES(3), .CNT_W(8)) u_p3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );
    nor_sweep_ctrl #(.SETTLE_CYCLES(2), .N_PASSES(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if5)
    );

    assign if0.y_gate = ~(if0.a | if0.b);
    assign if0.y_beh  = beh0_tie ? 1'b0 : ~(if0.a | if0.b);
    assign if0.y_df   = ~(if0.a | if0.b);
    assign if3.y_gate = ~(if3.a | if3.b);
    assign if3.y_beh  = ~(if3.a | if3.b);
    assign if3.y_df   = ~(if3.a | if3.b) ^ df3_inv;
    assign if5.y_gate = ~(if5.a | if5.b) ^ gate5_inv;
    assign if5.y_beh  = ~(if5.a | if5.b);
    assign if5.y_df   = ~(if5.a | if5.b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        beh0_tie  = 1'b0;
        df3_inv   = 1'b0;
        gate5_inv = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        if3.start = 1'b0; if3.abort = 1'b0;
        if5.start = 1'b0; if5.abort = 1'b0;
        tick(2);

        // Reset state
        chk("rst_busy",      {31'd0, if0.busy}, 32'd0);
        chk("rst_done",      {31'd0, if0.done}, 32'd0);
        chk("rst_pass",      {31'd0, if0.pass}, 32'd0);
        chk("rst_ab",        {30'd0, if0.a, if0.b}, 32'd0);
        chk("rst_err_gate",  {24'd0, if0.err_gate}, 32'd0);
        chk("rst_err_beh",   {24'd0, if0.err_beh}, 32'd0);
        chk("rst_err_df",    {24'd0, if0.err_df}, 32'd0);
        chk("rst_fail_seen", {31'd0, if0.fail_seen}, 32'd0);
        chk("rst_first",     {30'd0, if0.first_fail}, 32'd0);
        chk("rst_busy_p3",   {31'd0, if3.busy}, 32'd0);
        chk("rst_busy_sat",  {31'd0, if5.busy}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Test 1: all units correct, vectors step 00,01,10,11 three cycles apart
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        chk("t1_busy", {31'd0, if0.busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_ab_%0d", k), {30'd0, if0.a, if0.b}, k);
            tick(1);
            chk($sformatf("t1_ab_hold_%0d", k), {30'd0, if0.a, if0.b}, k);
            tick((k == 3) ? 1 : 2);
        end
        chk("t1_done_c12",   {31'd0, if0.done}, 32'd0);
        tick(1);
        chk("t1_done_c13",   {31'd0, if0.done}, 32'd1);
        chk("t1_pass",       {31'd0, if0.pass}, 32'd1);
        chk("t1_err_gate",   {24'd0, if0.err_gate}, 32'd0);
        chk("t1_err_beh",    {24'd0, if0.err_beh}, 32'd0);
        chk("t1_err_df",     {24'd0, if0.err_df}, 32'd0);
        chk("t1_fail_seen",  {31'd0, if0.fail_seen}, 32'd0);
        tick(1);
        chk("t1_done_pulse", {31'd0, if0.done}, 32'd0);
        chk("t1_busy_end",   {31'd0, if0.busy}, 32'd0);
        chk("t1_pass_hold",  {31'd0, if0.pass}, 32'd1);

        // Test 2: behavioural unit stuck at 0 fails only on vector 00
        beh0_tie  = 1'b1;
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        chk("t2_pass_clr",   {31'd0, if0.pass}, 32'd0);
        tick(12);
        chk("t2_done",       {31'd0, if0.done}, 32'd1);
        chk("t2_err_beh",    {24'd0, if0.err_beh}, 32'd1);
        chk("t2_err_gate",   {24'd0, if0.err_gate}, 32'd0);
        chk("t2_err_df",     {24'd0, if0.err_df}, 32'd0);
        chk("t2_first",      {30'd0, if0.first_fail}, 32'd0);
        chk("t2_fail_seen",  {31'd0, if0.fail_seen}, 32'd1);
        chk("t2_pass",       {31'd0, if0.pass}, 32'd0);
        tick(3);
        chk("t2_hold_err",   {24'd0, if0.err_beh}, 32'd1);

        // Test 4: abort during the second SETTLE keeps partial counts
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        chk("t4_err_clr",    {24'd0, if0.err_beh}, 32'd0);
        chk("t4_fs_clr",     {31'd0, if0.fail_seen}, 32'd0);
        tick(3);
        chk("t4_ab_vec1",    {30'd0, if0.a, if0.b}, 32'd1);
        if0.abort = 1'b1;
        tick(1);
        if0.abort = 1'b0;
        chk("t4_busy",       {31'd0, if0.busy}, 32'd0);
        chk("t4_err_part",   {24'd0, if0.err_beh}, 32'd1);
        chk("t4_ab_held",    {30'd0, if0.a, if0.b}, 32'd1);
        chk("t4_pass",       {31'd0, if0.pass}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t4_no_done_%0d", k), {31'd0, if0.done}, 32'd0);
            tick(1);
        end
        chk("t4_err_kept",   {24'd0, if0.err_beh}, 32'd1);
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        chk("t4_restart_clr", {24'd0, if0.err_beh}, 32'd0);
        tick(12);
        chk("t4_rerun_done", {31'd0, if0.done}, 32'd1);
        chk("t4_rerun_err",  {24'd0, if0.err_beh}, 32'd1);
        tick(1);

        // Test 6: start held high -> one run, then a fresh run from IDLE; then reset mid-run
        if0.start = 1'b1;
        tick(13);
        chk("t6_done",       {31'd0, if0.done}, 32'd1);
        chk("t6_pass",       {31'd0, if0.pass}, 32'd0);
        tick(1);
        chk("t6_done_once",  {31'd0, if0.done}, 32'd0);
        chk("t6_idle_gap",   {31'd0, if0.busy}, 32'd0);
        tick(1);
        chk("t6_rerun_busy", {31'd0, if0.busy}, 32'd1);
        if0.start = 1'b0;
        tick(5);
        chk("t6_mid_err",    {24'd0, if0.err_beh}, 32'd1);
        chk("t6_mid_ab",     {30'd0, if0.a, if0.b}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_busy",   {31'd0, if0.busy}, 32'd0);
        chk("t6_rst_ab",     {30'd0, if0.a, if0.b}, 32'd0);
        chk("t6_rst_err",    {24'd0, if0.err_beh}, 32'd0);
        chk("t6_rst_fs",     {31'd0, if0.fail_seen}, 32'd0);
        chk("t6_rst_done",   {31'd0, if0.done}, 32'd0);
        rst_n    = 1'b1;
        beh0_tie = 1'b0;
        tick(1);

        // Test 3: dataflow inverted, three passes -> 12 mismatches, done at cycle 37
        df3_inv   = 1'b1;
        if3.start = 1'b1;
        tick(1);
        if3.start = 1'b0;
        tick(35);
        chk("t3_done_c36",   {31'd0, if3.done}, 32'd0);
        tick(1);
        chk("t3_done_c37",   {31'd0, if3.done}, 32'd1);
        chk("t3_err_df",     {24'd0, if3.err_df}, 32'd12);
        chk("t3_err_gate",   {24'd0, if3.err_gate}, 32'd0);
        chk("t3_first",      {30'd0, if3.first_fail}, 32'd0);
        chk("t3_fail_seen",  {31'd0, if3.fail_seen}, 32'd1);
        chk("t3_pass",       {31'd0, if3.pass}, 32'd0);

        // Test 5: 2-bit counter, gate inverted, two passes -> saturates at 3
        gate5_inv = 1'b1;
        if5.start = 1'b1;
        tick(1);
        if5.start = 1'b0;
        tick(9);
        chk("t5_err_c10",    {30'd0, if5.err_gate}, 32'd3);
        tick(3);
        chk("t5_err_c13",    {30'd0, if5.err_gate}, 32'd3);
        tick(12);
        chk("t5_done",       {31'd0, if5.done}, 32'd1);
        chk("t5_err_sat",    {30'd0, if5.err_gate}, 32'd3);
        chk("t5_err_df",     {30'd0, if5.err_df}, 32'd0);
        chk("t5_pass",       {31'd0, if5.pass}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
